// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl: sequencer for the shared iterative multiply/divide unit, owner of HI/LO
//   clk, reset            : clock, synchronous active-high reset
//   start, op_div         : request pulse and op select (0 MULT, 1 DIV), taken only in IDLE
//   a_in, b_in            : operands (rs, rt) latched on an accepted start
//   hi_we, lo_we, wdata   : MTHI/MTLO writes, honoured only while idle
//   unit_hi, unit_lo      : results from the mult/div unit
//   unit_divzero          : divide-by-zero flag from the unit
//   unit_a, unit_b        : registered operands driven to the unit
//   unit_ctrl             : unit op select, 0 idle / 1 mult / 2 div
//   unit_reset            : unit clear
//   busy                  : operation in flight, stalls the control unit
//   done, div_zero        : one-cycle completion and divide-by-zero pulses
//   hi_q, lo_q            : architectural HI/LO
module muldiv_seq_ctrl #(
   parameter int MULT_CYCLES = 32,
   parameter int DIV_CYCLES  = 33
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op_div,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   input  logic [31:0] unit_hi,
   input  logic [31:0] unit_lo,
   input  logic        unit_divzero,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic [1:0]  unit_ctrl,
   output logic        unit_reset,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q
);
   typedef enum logic [1:0] {IDLE, CLEAR, RUN, CAPTURE} state_t;
   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d, last;
   logic        opsel_q, opsel_d;
   logic [31:0] unit_a_q, unit_a_d, unit_b_q, unit_b_d, hi_d, lo_d;
   logic        done_q, done_d, div_zero_q, div_zero_d;
   // cnt counts completed RUN edges minus one, so the edge where it equals
   // last is the LIMIT-th unit step
   assign last       = opsel_q ? 6'(DIV_CYCLES - 1) : 6'(MULT_CYCLES - 1);
   assign unit_ctrl  = (state_q == RUN) ? (opsel_q ? 2'd2 : 2'd1) : 2'd0;
   assign unit_reset = reset || state_q == CLEAR;
   assign busy       = state_q != IDLE;
   assign unit_a     = unit_a_q;
   assign unit_b     = unit_b_q;
   assign done       = done_q;
   assign div_zero   = div_zero_q;
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      opsel_d    = opsel_q;
      unit_a_d   = unit_a_q;
      unit_b_d   = unit_b_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      case (state_q)
         IDLE: begin
            hi_d = hi_we ? wdata : hi_q;
            lo_d = lo_we ? wdata : lo_q;
            if (start) begin
               unit_a_d = a_in;
               unit_b_d = b_in;
               opsel_d  = op_div;
               cnt_d    = 6'd0;
               state_d  = CLEAR;
            end
         end
         CLEAR: state_d = RUN;
         RUN: begin
            // a zero divisor aborts the divide; HI/LO are left untouched
            if (opsel_q && unit_divzero) begin
               state_d    = IDLE;
               done_d     = 1'b1;
               div_zero_d = 1'b1;
            end else begin
               cnt_d   = cnt_q + 6'd1;
               state_d = (cnt_q == last) ? CAPTURE : RUN;
            end
         end
         CAPTURE: begin
            hi_d    = unit_hi;
            lo_d    = unit_lo;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 6'd0;
         opsel_q    <= 1'b0;
         unit_a_q   <= 32'd0;
         unit_b_q   <= 32'd0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         opsel_q    <= opsel_d;
         unit_a_q   <= unit_a_d;
         unit_b_q   <= unit_b_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end
endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// tb_muldiv_seq_ctrl: self-checking bench for muldiv_seq_ctrl with a behavioural mult/div unit
module tb_muldiv_seq_ctrl;
   logic        clk = 1'b0;
   logic        reset, start, op_div, hi_we, lo_we, unit_divzero;
   logic [31:0] a_in, b_in, wdata, unit_hi, unit_lo;
   logic [31:0] unit_a, unit_b, hi_q, lo_q;
   logic [1:0]  unit_ctrl;
   logic        unit_reset, busy, done, div_zero;
   int          n_checks = 0, n_fail = 0;
   logic [5:0]  u_steps;
   logic [1:0]  u_mode;
   logic        u_dz;
   logic [63:0] u_res;

   always #5 clk = ~clk;

   muldiv_seq_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .op_div(op_div),
      .a_in(a_in), .b_in(b_in), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .unit_hi(unit_hi), .unit_lo(unit_lo), .unit_divzero(unit_divzero),
      .unit_a(unit_a), .unit_b(unit_b), .unit_ctrl(unit_ctrl), .unit_reset(unit_reset),
      .busy(busy), .done(done), .div_zero(div_zero), .hi_q(hi_q), .lo_q(lo_q)
   );

   // MIPS semantics: signed product {hi,lo}; divide gives {remainder, quotient}
   function automatic logic [63:0] ref_result(input logic op, input logic [31:0] a, input logic [31:0] b);
      longint p;
      if (!op) begin
         p = longint'($signed(a)) * longint'($signed(b));
         return 64'(p);
      end
      if (b == 32'd0) return 64'd0;
      if (b == 32'hFFFFFFFF) return {32'd0, 32'd0 - a};
      return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
   endfunction

   // unit model: result is only valid after exactly 32 mult / 33 div steps
   always @(posedge clk) begin
      if (unit_reset) begin
         u_steps <= 6'd0;
         u_mode  <= 2'd0;
         u_dz    <= 1'b0;
      end else if (unit_ctrl != 2'd0) begin
         u_steps <= u_steps + 6'd1;
         u_mode  <= unit_ctrl;
         if (unit_ctrl == 2'd2 && unit_b == 32'd0) u_dz <= 1'b1;
      end
   end

   always_comb begin
      u_res = ref_result(u_mode == 2'd2, unit_a, unit_b);
      if ((u_mode == 2'd1 && u_steps == 6'd32) || (u_mode == 2'd2 && u_steps == 6'd33)) begin
         unit_hi = u_res[63:32];
         unit_lo = u_res[31:0];
      end else begin
         unit_hi = 32'hBAD00000 | {26'd0, u_steps};
         unit_lo = 32'h0DD00000 | {26'd0, u_steps};
      end
   end
   assign unit_divzero = u_dz;

   task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b, input int glitch,
                        output int lat, output int ctrl_n, output logic busy_ok, output logic dz);
      int k;
      op_div = op; a_in = a; b_in = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; lat = -1; ctrl_n = 0; busy_ok = 1'b1; dz = 1'b0; k = 0;
      while (lat < 0 && k < 100) begin
         if (done === 1'b1) begin
            lat = k;
            dz  = div_zero;
         end else begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (unit_ctrl == (op ? 2'd2 : 2'd1)) ctrl_n++;
            else if (unit_ctrl != 2'd0) ctrl_n += 1000;
            if (k == glitch) begin
               start = 1'b1; op_div = 1'b0; a_in = 32'd3; b_in = 32'd4;
            end
            @(posedge clk); #1;
            start = 1'b0;
            k++;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 0; op_div = 0; a_in = 0; b_in = 0; hi_we = 0; lo_we = 0; wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0 || div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b/%b expected 0/0", done, div_zero); end
      n_checks++; if (hi_q !== 32'd0 || lo_q !== 32'd0) begin n_fail++; $display("FAIL reset_hilo: got %h/%h expected 0/0", hi_q, lo_q); end
      n_checks++; if (unit_a !== 32'd0 || unit_b !== 32'd0) begin n_fail++; $display("FAIL reset_operands: got %h/%h expected 0/0", unit_a, unit_b); end
      n_checks++; if (unit_ctrl !== 2'd0) begin n_fail++; $display("FAIL reset_ctrl: got %0d expected 0", unit_ctrl); end
      n_checks++; if (unit_reset !== 1'b1) begin n_fail++; $display("FAIL reset_unit_reset: got %b expected 1", unit_reset); end
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (unit_reset !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_release: got unit_reset %b busy %b expected 0 0", unit_reset, busy); end
   endtask

   task automatic test_mult();
      int lat, cn; logic bo, dz; logic [31:0] a, b; logic [63:0] e;
      do_op(1'b0, 32'd7, 32'hFFFFFFFD, -1, lat, cn, bo, dz);
      n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mult_latency: got %0d expected 34", lat); end
      n_checks++; if (cn !== 32) begin n_fail++; $display("FAIL mult_ctrl_cycles: got %0d expected 32", cn); end
      n_checks++; if (bo !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy: in-flight ok %b, at done %b expected 1 0", bo, busy); end
      n_checks++; if (hi_q !== 32'hFFFFFFFF || lo_q !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_result: got %h_%h expected ffffffff_ffffffeb", hi_q, lo_q); end
      n_checks++; if (unit_a !== 32'd7 || unit_b !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL mult_operands: got %h/%h expected 7/fffffffd", unit_a, unit_b); end
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_width: got %b expected 0", done); end
      repeat (6) begin
         a = $urandom; b = $urandom; e = ref_result(1'b0, a, b);
         do_op(1'b0, a, b, -1, lat, cn, bo, dz);
         n_checks++; if (lat !== 34 || cn !== 32) begin n_fail++; $display("FAIL mult_rand_timing: got lat %0d ctrl %0d expected 34 32", lat, cn); end
         n_checks++; if (hi_q !== e[63:32] || lo_q !== e[31:0]) begin n_fail++; $display("FAIL mult_rand_result %h*%h: got %h_%h expected %h", a, b, hi_q, lo_q, e); end
      end
   endtask

   task automatic test_div();
      int lat, cn; logic bo, dz; logic [31:0] a, b; logic [63:0] e;
      do_op(1'b1, 32'd100, 32'd7, -1, lat, cn, bo, dz);
      n_checks++; if (lat !== 35) begin n_fail++; $display("FAIL div_latency: got %0d expected 35", lat); end
      n_checks++; if (cn !== 33) begin n_fail++; $display("FAIL div_ctrl_cycles: got %0d expected 33", cn); end
      n_checks++; if (hi_q !== 32'd2 || lo_q !== 32'd14) begin n_fail++; $display("FAIL div_result: got hi %0d lo %0d expected 2 14", hi_q, lo_q); end
      n_checks++; if (dz !== 1'b0 || bo !== 1'b1) begin n_fail++; $display("FAIL div_flags: got div_zero %b busy_ok %b expected 0 1", dz, bo); end
      repeat (6) begin
         a = $urandom; b = 32'($urandom_range(1, 1000));
         if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
         e = ref_result(1'b1, a, b);
         do_op(1'b1, a, b, -1, lat, cn, bo, dz);
         n_checks++; if (lat !== 35 || cn !== 33 || dz !== 1'b0) begin n_fail++; $display("FAIL div_rand_timing: got lat %0d ctrl %0d dz %b expected 35 33 0", lat, cn, dz); end
         n_checks++; if (hi_q !== e[63:32] || lo_q !== e[31:0]) begin n_fail++; $display("FAIL div_rand_result %h/%h: got %h_%h expected %h", a, b, hi_q, lo_q, e); end
      end
   endtask

   task automatic test_div_zero();
      int lat, cn; logic bo, dz;
      hi_we = 1'b1; wdata = 32'h1234;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
      @(posedge clk); #1;
      lo_we = 1'b0;
      n_checks++; if (hi_q !== 32'h1234 || lo_q !== 32'h5678) begin n_fail++; $display("FAIL dz_preload: got %h/%h expected 1234/5678", hi_q, lo_q); end
      do_op(1'b1, 32'd5, 32'd0, -1, lat, cn, bo, dz);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL dz_latency: got %0d expected 3", lat); end
      n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b expected 1", dz); end
      n_checks++; if (hi_q !== 32'h1234 || lo_q !== 32'h5678 || busy !== 1'b0) begin n_fail++; $display("FAIL dz_hilo: got %h/%h busy %b expected 1234/5678 0", hi_q, lo_q, busy); end
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0 || div_zero !== 1'b0) begin n_fail++; $display("FAIL dz_pulse_width: got %b/%b expected 0/0", done, div_zero); end
      do_op(1'b1, $urandom, 32'd0, -1, lat, cn, bo, dz);
      n_checks++; if (lat !== 3 || dz !== 1'b1) begin n_fail++; $display("FAIL dz_rand: got lat %0d dz %b expected 3 1", lat, dz); end
   endtask

   task automatic test_back_to_back();
      int lat, cn; logic bo, dz;
      do_op(1'b1, 32'd100, 32'd7, 10, lat, cn, bo, dz);
      n_checks++; if (lat !== 35 || cn !== 33) begin n_fail++; $display("FAIL b2b_ignored_start: got lat %0d ctrl %0d expected 35 33", lat, cn); end
      n_checks++; if (hi_q !== 32'd2 || lo_q !== 32'd14) begin n_fail++; $display("FAIL b2b_div_result: got hi %0d lo %0d expected 2 14", hi_q, lo_q); end
      n_checks++; if (unit_a !== 32'd100 || unit_b !== 32'd7) begin n_fail++; $display("FAIL b2b_operands_stable: got %0d/%0d expected 100/7", unit_a, unit_b); end
      do_op(1'b0, 32'd3, 32'd4, -1, lat, cn, bo, dz);
      n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_accept_latency: got %0d expected 34", lat); end
      n_checks++; if (hi_q !== 32'd0 || lo_q !== 32'd12) begin n_fail++; $display("FAIL b2b_mult_result: got hi %0d lo %0d expected 0 12", hi_q, lo_q); end
   endtask

   task automatic test_mt_write();
      hi_we = 1'b1; wdata = 32'h1111;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2222;
      @(posedge clk); #1;
      lo_we = 1'b0;
      op_div = 1'b0; a_in = 32'd5; b_in = 32'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFEBABE;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
      n_checks++; if (hi_q !== 32'h1111 || lo_q !== 32'h2222) begin n_fail++; $display("FAIL mt_busy_ignored: got %h/%h expected 1111/2222", hi_q, lo_q); end
      for (int k = 0; k < 100 && done !== 1'b1; k++) begin @(posedge clk); #1; end
      n_checks++; if (done !== 1'b1 || hi_q !== 32'd0 || lo_q !== 32'd30) begin n_fail++; $display("FAIL mt_busy_op_result: got done %b %h/%h expected 1 0/1e", done, hi_q, lo_q); end
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFEBABE;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
      n_checks++; if (hi_q !== 32'hCAFEBABE || lo_q !== 32'hCAFEBABE) begin n_fail++; $display("FAIL mt_idle_write: got %h/%h expected cafebabe/cafebabe", hi_q, lo_q); end
      hi_we = 1'b1; wdata = 32'h55; op_div = 1'b0; a_in = 32'd2; b_in = 32'd8; start = 1'b1;
      @(posedge clk); #1;
      hi_we = 1'b0; start = 1'b0;
      n_checks++; if (hi_q !== 32'h55 || busy !== 1'b1) begin n_fail++; $display("FAIL mt_write_with_start: got hi %h busy %b expected 55 1", hi_q, busy); end
      for (int k = 0; k < 100 && done !== 1'b1; k++) begin @(posedge clk); #1; end
      n_checks++; if (done !== 1'b1 || hi_q !== 32'd0 || lo_q !== 32'd16) begin n_fail++; $display("FAIL mt_start_result: got done %b %h/%h expected 1 0/10", done, hi_q, lo_q); end
   endtask

   task automatic test_reset_mid();
      int dones;
      hi_we = 1'b1; wdata = 32'hAAAA;
      @(posedge clk); #1;
      hi_we = 1'b0;
      n_checks++; if (hi_q !== 32'hAAAA) begin n_fail++; $display("FAIL rmid_preload: got %h expected aaaa", hi_q); end
      op_div = 1'b0; a_in = 32'd9; b_in = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      n_checks++; if (unit_ctrl !== 2'd1) begin n_fail++; $display("FAIL rmid_in_run: got ctrl %0d expected 1", unit_ctrl); end
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0 || unit_reset !== 1'b1) begin n_fail++; $display("FAIL rmid_state: got busy %b unit_reset %b expected 0 1", busy, unit_reset); end
      n_checks++; if (hi_q !== 32'd0 || lo_q !== 32'd0 || done !== 1'b0) begin n_fail++; $display("FAIL rmid_clear: got %h/%h done %b expected 0/0 0", hi_q, lo_q, done); end
      reset = 1'b0;
      dones = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
      end
      n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d done pulses expected 0", dones); end
      n_checks++; if (unit_ctrl !== 2'd0 || unit_reset !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: got ctrl %0d unit_reset %b busy %b expected 0 0 0", unit_ctrl, unit_reset, busy); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_back_to_back();
      test_mt_write();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
